repeat_pattern_checker: RTL and testbench

- Receiver side of the alternating repeat-pattern stream: the generator toggles a WIDTH-bit word between a value and its bitwise complement every beat; this block checks that stream.
- Acquires lock on the alternation, then flags and counts any beat that breaks it.
- Declares loss of lock after consecutive errors.
- Sits at the sink end of pattern links and loopback test paths, feeding status registers and benches.

---
 rtl/repeat_pattern_checker.sv | 139 +++++++++++++
 tb/tb_repeat_pattern_checker.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/repeat_pattern_checker.sv
// repeat_pattern_checker
//   Sink-side checker for an alternating word/complement pattern stream.
//   It acquires lock after LOCK_COUNT correctly alternating beats. While
//   locked it flags and counts every beat that breaks the alternation, and
//   it drops lock after UNLOCK_ERRS consecutive bad beats.
//
// State table
//   state      | meaning
//   SEARCH     | no reference yet; the next valid beat seeds the prediction
//   LOCKING    | counting consecutive alternating beats toward lock
//   LOCKED     | lock held; mismatches are pulsed and counted
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_data carries a beat this cycle
//   in_data    received pattern word
//   clr_count  synchronous clear of err_count (wins over an increment)
//   locked     checker is in LOCKED
//   err_pulse  one-cycle pulse per mismatching beat while locked
//   lost_lock  one-cycle pulse when lock is dropped
//   err_count  saturating count of mismatches seen while locked
module repeat_pattern_checker #(
  parameter int WIDTH       = 3,
  parameter int LOCK_COUNT  = 4,
  parameter int UNLOCK_ERRS = 2,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 clr_count,
  output logic                 locked,
  output logic                 err_pulse,
  output logic                 lost_lock,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam int CE_W  = $clog2(UNLOCK_ERRS + 1);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_LOCKING = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  logic [1:0]           r_state;
  logic [WIDTH-1:0]     r_expected;
  logic [RUN_W-1:0]     r_run;
  logic [CE_W-1:0]      r_consec_err;
  logic                 r_locked;
  logic                 r_err_pulse;
  logic                 r_lost_lock;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic                 w_match;
  logic [RUN_W-1:0]     w_run_inc;
  logic [CE_W-1:0]      w_consec_inc;
  logic                 w_err_beat;

  assign w_match      = (in_data == r_expected);
  assign w_run_inc    = r_run + RUN_W'(1);
  assign w_consec_inc = r_consec_err + CE_W'(1);
  assign w_err_beat   = in_valid && (r_state == ST_LOCKED) && !w_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_SEARCH;
      r_expected   <= '0;
      r_run        <= '0;
      r_consec_err <= '0;
      r_locked     <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_lost_lock  <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      r_lost_lock <= 1'b0;
      if (in_valid) begin
        case (r_state)
          ST_SEARCH: begin
            r_expected <= ~in_data;
            r_run      <= RUN_W'(1);
            r_state    <= ST_LOCKING;
          end
          ST_LOCKING: begin
            // Both outcomes reseed the prediction from the current word;
            // a mismatch simply restarts the run at this beat.
            r_expected <= ~in_data;
            if (w_match) begin
              r_run <= w_run_inc;
              if (w_run_inc == RUN_W'(LOCK_COUNT)) begin
                r_state      <= ST_LOCKED;
                r_consec_err <= '0;
                r_locked     <= 1'b1;
              end
            end else begin
              r_run <= RUN_W'(1);
            end
          end
          ST_LOCKED: begin
            if (w_match) begin
              r_expected   <= ~in_data;
              r_consec_err <= '0;
            end else begin
              // Flywheel: advance the prediction from itself, not from the
              // corrupted word, so one bad beat costs exactly one error.
              r_expected   <= ~r_expected;
              r_err_pulse  <= 1'b1;
              r_consec_err <= w_consec_inc;
              if (w_consec_inc == CE_W'(UNLOCK_ERRS)) begin
                r_state     <= ST_SEARCH;
                r_locked    <= 1'b0;
                r_lost_lock <= 1'b1;
                r_run       <= '0;
              end
            end
          end
          default: r_state <= ST_SEARCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (clr_count) begin
      r_err_count <= '0;
    end else if (w_err_beat && !(&r_err_count)) begin
      r_err_count <= r_err_count + ERR_CNT_W'(1);
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign lost_lock = r_lost_lock;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_repeat_pattern_checker.sv
module tb_repeat_pattern_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // dut1: default parameters
  logic        v1, c1, l1, p1, ll1;
  logic [2:0]  d1;
  logic [15:0] cnt1;
  // dut2: narrow saturating counter, lock hard to lose
  logic        v2, c2, l2, p2, ll2;
  logic [2:0]  d2;
  logic [1:0]  cnt2;

  repeat_pattern_checker #(.WIDTH(3), .LOCK_COUNT(4), .UNLOCK_ERRS(2), .ERR_CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(d1), .clr_count(c1),
    .locked(l1), .err_pulse(p1), .lost_lock(ll1), .err_count(cnt1));

  repeat_pattern_checker #(.WIDTH(3), .LOCK_COUNT(4), .UNLOCK_ERRS(8), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_data(d2), .clr_count(c2),
    .locked(l2), .err_pulse(p2), .lost_lock(ll2), .err_count(cnt2));

  typedef struct {
    bit          sel;
    bit          lk;
    bit          ep;
    bit          ll;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [18:0] act, input logic [18:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got lk=%0b ep=%0b ll=%0b cnt=%0d required lk=%0b ep=%0b ll=%0b cnt=%0d",
               nm, act[18], act[17], act[16], act[15:0], req[18], req[17], req[16], req[15:0]);
    end
  endtask

  function automatic logic [18:0] outs(input bit sel);
    if (sel) return {l2, p2, ll2, 14'd0, cnt2};
    return {l1, p1, ll1, cnt1};
  endfunction

  // Monitor: every beat driven before a rising edge has its response checked
  // just after that edge.
  exp_t e;
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.name, outs(e.sel), {e.lk, e.ep, e.ll, e.cnt});
    end
  end

  task automatic step(input bit sel, input bit v, input logic [2:0] d, input bit clr,
                      input bit lk, input bit ep, input bit ll, input logic [15:0] cnt,
                      input string nm);
    exp_t x;
    @(negedge clk);
    if (sel) begin v2 = v; d2 = d; c2 = clr; end
    else     begin v1 = v; d1 = d; c1 = clr; end
    x.sel = sel; x.lk = lk; x.ep = ep; x.ll = ll; x.cnt = cnt; x.name = nm;
    q.push_back(x);
    @(posedge clk);
    #2;
    v1 = 1'b0; c1 = 1'b0; v2 = 1'b0; c2 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    v1 = 1'b0; d1 = 3'd0; c1 = 1'b0;
    v2 = 1'b0; d2 = 3'd0; c2 = 1'b0;
    #12;
    chk("reset_dut1", outs(0), 19'd0);
    chk("reset_dut2", outs(1), 19'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // constant input never locks
    for (int i = 0; i < 5; i++) step(0, 1, 3'd0, 0, 0, 0, 0, 16'd0, "const_zero");
    // lock on 0,7,0,7
    step(0, 1, 3'd0, 0, 0, 0, 0, 16'd0, "lock_b1");
    step(0, 1, 3'd7, 0, 0, 0, 0, 16'd0, "lock_b2");
    step(0, 1, 3'd0, 0, 0, 0, 0, 16'd0, "lock_b3");
    step(0, 1, 3'd7, 0, 1, 0, 0, 16'd0, "lock_b4");
    // single corrupted beat, flywheel keeps phase
    step(0, 1, 3'd0, 0, 1, 0, 0, 16'd0, "single_0");
    step(0, 1, 3'd7, 0, 1, 0, 0, 16'd0, "single_7");
    step(0, 1, 3'd5, 0, 1, 1, 0, 16'd1, "single_err");
    step(0, 1, 3'd7, 0, 1, 0, 0, 16'd1, "single_fly7");
    step(0, 1, 3'd0, 0, 1, 0, 0, 16'd1, "single_fly0");
    step(0, 1, 3'd7, 0, 1, 0, 0, 16'd1, "single_fly7b");
    // 7,7,7 against expected 0,7,0
    step(0, 1, 3'd7, 0, 1, 1, 0, 16'd2, "sep_err1");
    step(0, 1, 3'd7, 0, 1, 0, 0, 16'd2, "sep_match");
    step(0, 1, 3'd7, 0, 1, 1, 0, 16'd3, "sep_err2");
    step(0, 1, 3'd7, 0, 1, 0, 0, 16'd3, "sep_match2");
    // two consecutive errors drop lock
    step(0, 1, 3'd3, 0, 1, 1, 0, 16'd4, "unlock_err1");
    step(0, 1, 3'd3, 0, 0, 1, 1, 16'd5, "unlock_err2");
    step(0, 0, 3'd3, 0, 0, 0, 0, 16'd5, "unlock_after");
    // gaps and reseed in LOCKING
    step(0, 1, 3'd0, 0, 0, 0, 0, 16'd5, "gap_seed");
    for (int i = 0; i < 5; i++) step(0, 0, 3'd5, 0, 0, 0, 0, 16'd5, "gap_idle");
    step(0, 1, 3'd7, 0, 0, 0, 0, 16'd5, "gap_7");
    step(0, 1, 3'd0, 0, 0, 0, 0, 16'd5, "gap_0");
    step(0, 1, 3'd4, 0, 0, 0, 0, 16'd5, "reseed_4");
    step(0, 1, 3'd3, 0, 0, 0, 0, 16'd5, "reseed_3");
    step(0, 1, 3'd4, 0, 0, 0, 0, 16'd5, "reseed_4b");
    step(0, 1, 3'd3, 0, 1, 0, 0, 16'd5, "reseed_lock");
    // clear on a matching beat: lock untouched
    step(0, 1, 3'd4, 1, 1, 0, 0, 16'd0, "clr_match");
    // build up some errors, then async reset between edges
    step(0, 1, 3'd0, 0, 1, 1, 0, 16'd1, "pre_rst_err1");
    step(0, 1, 3'd4, 0, 1, 0, 0, 16'd1, "pre_rst_match");
    step(0, 1, 3'd0, 0, 1, 1, 0, 16'd2, "pre_rst_err2");
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", outs(0), 19'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 3'd0, 0, 0, 0, 0, 16'd0, "relock_b1");
    step(0, 1, 3'd7, 0, 0, 0, 0, 16'd0, "relock_b2");
    step(0, 1, 3'd0, 0, 0, 0, 0, 16'd0, "relock_b3");
    step(0, 1, 3'd7, 0, 1, 0, 0, 16'd0, "relock_b4");

    // dut2: saturation and clear priority
    step(1, 1, 3'd0, 0, 0, 0, 0, 16'd0, "sat_lock1");
    step(1, 1, 3'd7, 0, 0, 0, 0, 16'd0, "sat_lock2");
    step(1, 1, 3'd0, 0, 0, 0, 0, 16'd0, "sat_lock3");
    step(1, 1, 3'd7, 0, 1, 0, 0, 16'd0, "sat_lock4");
    step(1, 1, 3'd7, 0, 1, 1, 0, 16'd1, "sat_err1");
    step(1, 1, 3'd0, 0, 1, 1, 0, 16'd2, "sat_err2");
    step(1, 1, 3'd7, 0, 1, 1, 0, 16'd3, "sat_err3");
    step(1, 1, 3'd0, 0, 1, 1, 0, 16'd3, "sat_err4_hold");
    step(1, 1, 3'd7, 0, 1, 1, 0, 16'd3, "sat_err5_hold");
    step(1, 1, 3'd7, 0, 1, 0, 0, 16'd3, "sat_match");
    step(1, 1, 3'd7, 1, 1, 1, 0, 16'd0, "clr_vs_err");
    step(1, 1, 3'd7, 0, 1, 0, 0, 16'd0, "clr_after");

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d pending required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
